ddio_in: RTL
============

Name: ddio_in

Overview:
- Double-data-rate input capture for the HDMI path; the receive-side counterpart of the DDR output stage.
- Samples a WIDTH-bit pad bus on both edges of clk and presents each rise/fall pair as two parallel words in the posedge domain.
- Includes a training-pattern lock FSM that detects a half-cycle slip between the sender's high/low phases and the local edges, then swaps the pairing to correct it.

Parameters:
WIDTH, 8, data bus width per edge
TRAIN_PAT_H, 8'hAA, expected high-phase training word (WIDTH bits)
TRAIN_PAT_L, 8'h55, expected low-phase training word (WIDTH bits)
LOCK_COUNT, 4, consecutive matching pairs required to lock (>=1)

Ports:
clk  input  1  system clock; both edges used for capture
sclr  input  1  synchronous active-high reset
clk_en  input  1  posedge-stage enable
datain  input  WIDTH  DDR pad data
train_start  input  1  single-cycle pulse; starts or restarts training
dataout_h  output  WIDTH  word sent on the sender's high phase
dataout_l  output  WIDTH  word sent on the sender's low phase
valid  output  1  dataout_h/l updated this cycle
locked  output  1  training pattern locked
swapped  output  1  1 = pairing corrected by half a cycle

Behaviour:
- Capture registers:
  - rise_q <= datain on posedge, gated by clk_en.
  - fall_q <= datain on negedge, ungated.
  - fall_d <= fall_q on posedge, gated by clk_en.
- Reset:
  - sclr is sampled on posedge; it clears every posedge register, outputs, counters and FSM.
  - fall_q clears on any negedge where sclr=1.
  - Reset values: dataout_h=0, dataout_l=0, valid=0, locked=0, swapped=0, FSM=IDLE, both counters=0.
  - sclr has priority over every other input.
- Pairing at posedge n+1 (H_n = rise_q from posedge n, L_n = fall_q from the following negedge):
  - swapped=0: dataout_h <= rise_q (H_n), dataout_l <= fall_q (L_n).
  - swapped=1: dataout_h <= fall_d (L_{n-1}), dataout_l <= rise_q (H_n).
- Latency and enable:
  - Non-swapped latency is 1 posedge from the H sample to output.
  - valid <= clk_en each posedge.
  - When clk_en=0, dataout_h/l hold and valid=0 on the next cycle.
- Candidate pairs evaluated each posedge with clk_en=1:
  - N-pair = (rise_q, fall_q).
  - S-pair = (fall_d, rise_q).
  - A pair matches when it equals (TRAIN_PAT_H, TRAIN_PAT_L).
- FSM, posedge, states IDLE / HUNT / LOCKED:
  - IDLE: train_start=1 -> HUNT, cnt_n=cnt_s=0.
  - HUNT, clk_en=1:
    - N match: cnt_n++, else cnt_n=0.
    - S match: cnt_s++, else cnt_s=0.
    - Both update in the same cycle.
  - HUNT, clk_en=0: counters hold.
  - HUNT exit: when an updated count reaches LOCK_COUNT -> LOCKED, locked=1, swapped = (cnt_s reached && !cnt_n reached).
  - N has priority on simultaneous reach, e.g. when TRAIN_PAT_H==TRAIN_PAT_L.
  - HUNT, train_start=1: counters cleared, stay in HUNT; this overrides the match update that cycle.
  - LOCKED: holds indefinitely, and data keeps flowing.
  - LOCKED, train_start=1 -> HUNT, locked <= 0, counters cleared.
- swapped is retained through HUNT and updates only on lock, so data pairing is stable during retraining.
- Counter width: $clog2(LOCK_COUNT+1); counters saturate at LOCK_COUNT.
- sclr mid-HUNT or mid-LOCKED returns to IDLE with all reset values next cycle.

Test Plan:
- Reset: hold sclr=1 for 3 cycles with datain toggling -> dataout_h=dataout_l=0, valid=0, locked=0, swapped=0.
- Aligned data, clk_en=1, swapped=0: drive datain 8'h12 at posedge and 8'h34 at negedge -> the next posedge gives dataout_h=8'h12, dataout_l=8'h34, valid=1.
- Aligned training:
  - Pulse train_start, then send pairs AA/55 with H on posedge.
  - Required: locked=1 exactly after the 4th matching posedge, swapped=0.
  - A single 8'h00 word mid-sequence resets cnt_n and delays lock by 4 more pairs.
- Slipped training:
  - Send 55 on posedge and AA on negedge (sender's H lands on negedge).
  - Required: lock after 4 matches with swapped=1.
  - Then send H=8'hC3 on negedge followed by L=8'h3C on the next posedge -> dataout_h=8'hC3, dataout_l=8'h3C.
- clk_en gaps: during HUNT toggle clk_en 1,0,1,... with pattern AA/55 -> counters hold while clk_en=0, valid follows clk_en one cycle late, lock after 4 enabled matches.
- Retrain and reset:
  - In LOCKED with swapped=1, pulse train_start -> locked=0 next cycle, swapped stays 1 until the new lock.
  - Assert sclr during HUNT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/ddio_in_if.sv
// ============================================================================
// Module      : ddio_in_if
// Description : Bundles the enable, pad data, training control and
//               parallel-output signals of the DDR input capture stage.
//               master : drives clk_en, datain, train_start (sender/controller)
//               slave  : the capture block; drives dataout_h/l, valid,
//                        locked, swapped
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ddio_in_if #(
  parameter int WIDTH = 8
);
  logic             clk_en;       // posedge-stage enable
  logic [WIDTH-1:0] datain;       // DDR pad data
  logic             train_start;  // single-cycle training (re)start pulse
  logic [WIDTH-1:0] dataout_h;    // word sent on the sender's high phase
  logic [WIDTH-1:0] dataout_l;    // word sent on the sender's low phase
  logic             valid;        // dataout_h/l updated this cycle
  logic             locked;       // training pattern locked
  logic             swapped;      // pairing corrected by half a cycle

  modport master (
    output clk_en, datain, train_start,
    input  dataout_h, dataout_l, valid, locked, swapped
  );

  modport slave (
    input  clk_en, datain, train_start,
    output dataout_h, dataout_l, valid, locked, swapped
  );
endinterface

`default_nettype wire

// File: rtl/ddio_in.sv
// ============================================================================
// Module      : ddio_in
// Description : Double-data-rate input capture. Samples the pad bus on both
//               clock edges and presents each rise/fall pair as two parallel
//               words in the posedge domain. A training-pattern lock FSM
//               detects a half-cycle slip between the sender's high/low
//               phases and the local edges, and swaps the pairing to fix it.
// Ports       : clk   - capture clock, both edges used
//               sclr  - synchronous active-high clear (priority over all)
//               bus   - ddio_in_if.slave: clk_en, datain, train_start in;
//                       dataout_h, dataout_l, valid, locked, swapped out
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ddio_in #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TRAIN_PAT_H = WIDTH'(8'hAA),
  parameter logic [WIDTH-1:0] TRAIN_PAT_L = WIDTH'(8'h55),
  parameter int               LOCK_COUNT  = 4
) (
  input  wire logic  clk,
  input  wire logic  sclr,
  ddio_in_if.slave   bus
);

  localparam int             CNT_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Capture registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] rise_q;   // word sampled on the last enabled posedge
  logic [WIDTH-1:0] fall_q;   // word sampled on the last negedge
  logic [WIDTH-1:0] fall_d;   // fall_q as it stood at the last enabled posedge
  logic [WIDTH-1:0] out_h;
  logic [WIDTH-1:0] out_l;
  logic             valid_q;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_n_next;
  logic [CNT_W-1:0] cnt_s_next;
  logic             swapped_q;
  logic             swapped_next;

  // The negedge sample is not gated by clk_en: the low-phase word must always
  // be current when the next posedge pairs it.
  always_ff @(negedge clk) begin
    if (sclr) begin
      fall_q <= '0;
    end else begin
      fall_q <= bus.datain;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      rise_q  <= '0;
      fall_d  <= '0;
      out_h   <= '0;
      out_l   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.clk_en;
      if (bus.clk_en) begin
        // Slipped sender: its high word arrived on the previous negedge
        // (fall_d) and its low word on this posedge's sample (rise_q).
        if (swapped_q) begin
          out_h <= fall_d;
          out_l <= rise_q;
        end else begin
          out_h <= rise_q;
          out_l <= fall_q;
        end
        rise_q <= bus.datain;
        fall_d <= fall_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Training lock FSM
  // --------------------------------------------------------------------------
  logic             n_match;
  logic             s_match;
  logic [CNT_W-1:0] n_upd;
  logic [CNT_W-1:0] s_upd;
  logic             n_reach;
  logic             s_reach;

  assign n_match = (rise_q == TRAIN_PAT_H) && (fall_q == TRAIN_PAT_L);
  assign s_match = (fall_d == TRAIN_PAT_H) && (rise_q == TRAIN_PAT_L);

  // Run-length of consecutive matches, saturating at the lock threshold.
  assign n_upd   = !n_match ? '0 : ((cnt_n == CNT_MAX) ? cnt_n : cnt_n + CNT_W'(1));
  assign s_upd   = !s_match ? '0 : ((cnt_s == CNT_MAX) ? cnt_s : cnt_s + CNT_W'(1));
  assign n_reach = (n_upd == CNT_MAX);
  assign s_reach = (s_upd == CNT_MAX);

  always_ff @(posedge clk) begin
    if (sclr) begin
      state     <= IDLE;
      cnt_n     <= '0;
      cnt_s     <= '0;
      swapped_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt_n     <= cnt_n_next;
      cnt_s     <= cnt_s_next;
      swapped_q <= swapped_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_n_next   = cnt_n;
    cnt_s_next   = cnt_s;
    swapped_next = swapped_q;
    case (state)
      IDLE: begin
        if (bus.train_start) begin
          state_next = HUNT;
          cnt_n_next = '0;
          cnt_s_next = '0;
        end
      end
      HUNT: begin
        if (bus.train_start) begin
          cnt_n_next = '0;
          cnt_s_next = '0;
        end else if (bus.clk_en) begin
          cnt_n_next = n_upd;
          cnt_s_next = s_upd;
          if (n_reach || s_reach) begin
            state_next   = LOCKED;
            // Straight pairing wins a tie (e.g. identical H/L patterns).
            swapped_next = s_reach && !n_reach;
          end
        end
      end
      LOCKED: begin
        if (bus.train_start) begin
          state_next = HUNT;
          cnt_n_next = '0;
          cnt_s_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.dataout_h = out_h;
  assign bus.dataout_l = out_l;
  assign bus.valid     = valid_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.swapped   = swapped_q;

endmodule

`default_nettype wire
